// File: rtl/scarv_cop_sg_engine.sv
// Scatter/gather engine for the SCARV coprocessor. It makes one bus access per packed CPR
// element and writes gathered data back in a single all-or-nothing update.
module scarv_cop_sg_engine #(
   parameter int XLEN = 32,
   parameter int AW   = 32
) (
   input  logic                      g_clk,
   input  logic                      g_resetn,
   input  logic                      sg_ivalid,
   input  logic                      sg_is_store,
   input  logic [1:0]                sg_esize,
   input  logic [AW-1:0]             gpr_base,
   input  logic [XLEN-1:0]           cpr_offsets,
   input  logic [XLEN-1:0]           cpr_wdata,
   output logic                      sg_idone,
   output logic                      sg_addr_error,
   output logic                      sg_bus_error,
   output logic [$clog2(XLEN/8)-1:0] sg_fault_idx,
   output logic [XLEN-1:0]           sg_rd_wdata,
   output logic [XLEN/8-1:0]         sg_rd_ben,
   output logic                      mem_req,
   input  logic                      mem_gnt,
   output logic                      mem_wen,
   output logic [AW-1:0]             mem_addr,
   output logic [XLEN-1:0]           mem_wdata,
   output logic [XLEN/8-1:0]         mem_ben,
   input  logic                      mem_rvalid,
   input  logic [XLEN-1:0]           mem_rdata,
   input  logic                      mem_error
);
   localparam int NB = XLEN / 8;
   localparam int LW = $clog2(NB);

   typedef enum logic [2:0] {IDLE, REQ, RSP, DRAIN, FIN} state_t;

   state_t          state, state_nxt;
   logic [LW-1:0]   idx, lane_q, fin_idx;
   logic [XLEN-1:0] gbuf;
   logic            fin_aerr, fin_berr, fin_wb;

   function automatic logic [XLEN-1:0] elem_mask(input logic [1:0] es);
      int              w;
      logic [XLEN-1:0] one;
      w      = 8 << es;
      one    = '0;
      one[0] = 1'b1;
      return (w >= XLEN) ? '1 : (one << w) - one;
   endfunction

   function automatic logic [XLEN-1:0] field(input logic [XLEN-1:0] v, input logic [1:0] es,
                                             input int i);
      return (v >> (i << (int'(es) + 3))) & elem_mask(es);
   endfunction

   function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] base,
                                               input logic [XLEN-1:0] offs,
                                               input logic [1:0] es, input int i);
      return base + AW'(field(offs, es, i));
   endfunction

   function automatic logic misaligned(input logic [AW-1:0] a, input logic [1:0] es);
      return (int'(a[LW-1:0]) & ((1 << es) - 1)) != 0;
   endfunction

   int              nelem;
   logic            chk_err, last;
   logic [LW-1:0]   chk_idx, cur_lane;
   logic [AW-1:0]   cur_addr;
   logic [XLEN-1:0] emask, ins_data, gbuf_ins;
   int              sh;

   // Whole-instruction alignment check, done up front so a bad element issues no bus traffic.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      nelem   = NB >> sg_esize;
      chk_err = 1'b0;
      chk_idx = '0;
      if (XLEN == 32 && sg_esize == 2'd3) begin
         chk_err = 1'b1;
      end else begin
         for (int i = NB - 1; i >= 0; i--) begin
            if (i < nelem && misaligned(elem_addr(gpr_base, cpr_offsets, sg_esize, i), sg_esize)) begin
               chk_err = 1'b1;
               chk_idx = LW'(i);
            end
         end
      end
   end

   always_comb begin
      emask    = elem_mask(sg_esize);
      sh       = int'(idx) << (int'(sg_esize) + 3);
      cur_addr = elem_addr(gpr_base, cpr_offsets, sg_esize, int'(idx));
      cur_lane = cur_addr[LW-1:0];
      ins_data = (mem_rdata >> (int'(lane_q) * 8)) & emask;
      gbuf_ins = (gbuf & ~(emask << sh)) | (ins_data << sh);
      last     = (int'(idx) == nelem - 1);
   end

   always_ff @(posedge g_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!g_resetn) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (sg_ivalid) state_nxt = chk_err ? FIN : REQ;
         // A grant that coincides with an abort still owes us a response, so drain it.
         REQ:   if (mem_gnt)         state_nxt = sg_ivalid ? RSP : DRAIN;
                else if (!sg_ivalid) state_nxt = IDLE;
         RSP:   if (mem_rvalid)      state_nxt = !sg_ivalid ? IDLE : (mem_error || last) ? FIN : REQ;
                else if (!sg_ivalid) state_nxt = DRAIN;
         DRAIN: if (mem_rvalid) state_nxt = IDLE;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         idx      <= '0;
         lane_q   <= '0;
         gbuf     <= '0;
         fin_idx  <= '0;
         fin_aerr <= 1'b0;
         fin_berr <= 1'b0;
         fin_wb   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (sg_ivalid) begin
               idx      <= '0;
               gbuf     <= '0;
               fin_aerr <= chk_err;
               fin_idx  <= chk_idx;
               fin_berr <= 1'b0;
               fin_wb   <= 1'b0;
            end
            REQ: if (mem_gnt) lane_q <= cur_lane;
            RSP: if (mem_rvalid && sg_ivalid) begin
               if (mem_error) begin
                  fin_berr <= 1'b1;
                  fin_idx  <= idx;
               end else begin
                  if (!sg_is_store) gbuf <= gbuf_ins;
                  if (last) fin_wb <= !sg_is_store;
                  else      idx    <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sg_idone      = 1'b0;
      sg_addr_error = 1'b0;
      sg_bus_error  = 1'b0;
      sg_fault_idx  = '0;
      sg_rd_wdata   = '0;
      sg_rd_ben     = '0;
      mem_req       = 1'b0;
      mem_wen       = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_ben       = '0;
      case (state)
         REQ: begin
            mem_req  = 1'b1;
            mem_wen  = sg_is_store;
            mem_addr = cur_addr & ~AW'(NB - 1);
            if (sg_is_store) begin
               mem_wdata = field(cpr_wdata, sg_esize, int'(idx)) << (int'(cur_lane) * 8);
               mem_ben   = NB'((1 << (1 << sg_esize)) - 1) << cur_lane;
            end
         end
         FIN: begin
            sg_idone      = 1'b1;
            sg_addr_error = fin_aerr;
            sg_bus_error  = fin_berr;
            sg_fault_idx  = fin_idx;
            if (fin_wb) begin
               sg_rd_ben   = '1;
               sg_rd_wdata = gbuf;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_scarv_cop_sg_engine.sv
// Directed bench for scarv_cop_sg_engine (XLEN=32): a single-outstanding bus responder
// with grant/response gating, and hand-computed expectations for each instruction.
module tb_scarv_cop_sg_engine;
   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;
   logic        sg_ivalid = 1'b0, sg_is_store = 1'b0;
   logic [1:0]  sg_esize = '0;
   logic [31:0] gpr_base = '0, cpr_offsets = '0, cpr_wdata = '0;
   logic        sg_idone, sg_addr_error, sg_bus_error;
   logic [1:0]  sg_fault_idx;
   logic [31:0] sg_rd_wdata;
   logic [3:0]  sg_rd_ben;
   logic        mem_req, mem_wen;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_error = 1'b0;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [3:0]  mem_ben;

   scarv_cop_sg_engine #(.XLEN(32), .AW(32)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .sg_ivalid(sg_ivalid), .sg_is_store(sg_is_store),
      .sg_esize(sg_esize), .gpr_base(gpr_base), .cpr_offsets(cpr_offsets), .cpr_wdata(cpr_wdata),
      .sg_idone(sg_idone), .sg_addr_error(sg_addr_error), .sg_bus_error(sg_bus_error),
      .sg_fault_idx(sg_fault_idx), .sg_rd_wdata(sg_rd_wdata), .sg_rd_ben(sg_rd_ben),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ben(mem_ben), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mem_error(mem_error)
   );

   always #5 g_clk = ~g_clk;

   int errors = 0, checks = 0;

   // Responder controls and observation log.
   bit          gnt_en = 1'b1, rsp_en = 1'b1, pending = 1'b0;
   int          err_at = -1, rsp_cnt = 0;
   logic [31:0] rd_val = '0;
   int          log_n = 0, req_seen = 0, steps = 0, first_req = -1, done_step = -1, idone_cnt = 0;
   logic [31:0] log_addr[8], log_wdata[8];
   logic [3:0]  log_ben[8];
   logic        log_wen[8];
   logic [31:0] cap_wdata;
   logic [3:0]  cap_ben;
   logic        cap_aerr, cap_berr;
   logic [1:0]  cap_fidx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: observe outputs at the negedge, then drive the bus inputs for the next posedge.
   task automatic step();
      @(negedge g_clk);
      steps++;
      if (sg_idone) begin
         idone_cnt++;
         done_step = steps;
         cap_wdata = sg_rd_wdata;
         cap_ben   = sg_rd_ben;
         cap_aerr  = sg_addr_error;
         cap_berr  = sg_bus_error;
         cap_fidx  = sg_fault_idx;
      end
      if (mem_req) begin
         req_seen++;
         if (first_req < 0) first_req = steps;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_error  = 1'b0;
      mem_rdata  = rd_val;
      if (pending && rsp_en) begin
         mem_rvalid = 1'b1;
         mem_error  = (rsp_cnt == err_at);
         rsp_cnt++;
         pending = 1'b0;
      end
      if (mem_req && gnt_en && !mem_rvalid) begin
         mem_gnt = 1'b1;
         pending = 1'b1;
         if (log_n < 8) begin
            log_addr[log_n]  = mem_addr;
            log_wdata[log_n] = mem_wdata;
            log_ben[log_n]   = mem_ben;
            log_wen[log_n]   = mem_wen;
         end
         log_n++;
      end
   endtask

   task automatic start(input logic st, input logic [1:0] es, input logic [31:0] base,
                        input logic [31:0] offs, input logic [31:0] wd);
      sg_is_store = st;
      sg_esize    = es;
      gpr_base    = base;
      cpr_offsets = offs;
      cpr_wdata   = wd;
      sg_ivalid   = 1'b1;
      rsp_cnt     = 0;
      log_n       = 0;
      req_seen    = 0;
      steps       = 0;
      first_req   = -1;
      done_step   = -1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int i0;
      i0 = idone_cnt;
      for (int k = 0; k < budget && idone_cnt == i0; k++) step();
      check({tag, " idone"}, 64'(idone_cnt), 64'(i0 + 1));
      sg_ivalid = 1'b0;
      step();
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " idone"}, sg_idone, 0);
      check({tag, " aerr"}, sg_addr_error, 0);
      check({tag, " berr"}, sg_bus_error, 0);
      check({tag, " fidx"}, sg_fault_idx, 0);
      check({tag, " rd_ben"}, sg_rd_ben, 0);
      check({tag, " rd_wdata"}, sg_rd_wdata, 0);
      check({tag, " mem_req"}, mem_req, 0);
      check({tag, " mem_wen"}, mem_wen, 0);
      check({tag, " mem_addr"}, mem_addr, 0);
      check({tag, " mem_wdata"}, mem_wdata, 0);
      check({tag, " mem_ben"}, mem_ben, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0;
      repeat (3) step();
      check_quiet("reset");
      g_resetn = 1'b1;
      step();

      // 1: byte gather, all four elements in one word; first request to idone is 4 x 2 cycles.
      rd_val = 32'hDDCCBBAA;
      start(1'b0, 2'd0, 32'h1000, 32'h03020100, '0);
      wait_done("t1", 40);
      check("t1 nreq", 64'(log_n), 4);
      for (int k = 0; k < 4; k++) check("t1 addr", log_addr[k], 32'h1000);
      check("t1 wen", log_wen[0], 0);
      check("t1 ben", log_ben[0], 0);
      check("t1 first_req", 64'(first_req), 1);
      check("t1 latency", 64'(done_step - first_req), 8);
      check("t1 rd_wdata", cap_wdata, 32'hDDCCBBAA);
      check("t1 rd_ben", cap_ben, 4'hF);
      check("t1 aerr", cap_aerr, 0);
      check("t1 berr", cap_berr, 0);

      // 2: halfword scatter, second element in the upper half of word 0x2004.
      start(1'b1, 2'd1, 32'h2000, 32'h00060000, 32'hBEEF1234);
      wait_done("t2", 40);
      check("t2 nreq", 64'(log_n), 2);
      check("t2 addr0", log_addr[0], 32'h2000);
      check("t2 ben0", log_ben[0], 4'h3);
      check("t2 wdata0", log_wdata[0], 32'h00001234);
      check("t2 wen0", log_wen[0], 1);
      check("t2 addr1", log_addr[1], 32'h2004);
      check("t2 ben1", log_ben[1], 4'hC);
      check("t2 wdata1", log_wdata[1], 32'hBEEF0000);
      check("t2 rd_ben", cap_ben, 0);
      check("t2 rd_wdata", cap_wdata, 0);

      // 3: misaligned element 1, then illegal dword size.
      start(1'b0, 2'd1, 32'h1000, 32'h00030000, '0);
      wait_done("t3a", 10);
      check("t3a aerr", cap_aerr, 1);
      check("t3a fidx", cap_fidx, 1);
      check("t3a berr", cap_berr, 0);
      check("t3a no req", 64'(req_seen), 0);
      check("t3a latency", 64'(done_step), 1);
      check("t3a rd_ben", cap_ben, 0);
      start(1'b0, 2'd3, 32'h1000, '0, '0);
      wait_done("t3b", 10);
      check("t3b aerr", cap_aerr, 1);
      check("t3b fidx", cap_fidx, 0);
      check("t3b no req", 64'(req_seen), 0);

      // 4: bus error on element 2 of a byte gather.
      err_at = 2;
      start(1'b0, 2'd0, 32'h1000, 32'h03020100, '0);
      wait_done("t4", 40);
      err_at = -1;
      check("t4 berr", cap_berr, 1);
      check("t4 aerr", cap_aerr, 0);
      check("t4 fidx", cap_fidx, 2);
      check("t4 rd_ben", cap_ben, 0);
      check("t4 rd_wdata", cap_wdata, 0);
      check("t4 nreq", 64'(log_n), 3);

      // 5a: grant withheld for 5 cycles, then abort from REQ.
      i0 = idone_cnt;
      gnt_en = 1'b0;
      start(1'b0, 2'd2, 32'h3000, 32'h00000010, '0);
      repeat (5) step();
      check("t5a req held", 64'(req_seen), 5);
      check("t5a addr", mem_addr, 32'h3010);
      sg_ivalid = 1'b0;
      repeat (3) step();
      gnt_en = 1'b1;
      step();
      check("t5a mem_req", mem_req, 0);
      check("t5a no req after", 64'(req_seen), 5);
      check("t5a no idone", 64'(idone_cnt), 64'(i0));

      // 5b: abort in RSP; the late response is swallowed, then a fresh gather completes.
      rsp_en = 1'b0;
      start(1'b0, 2'd0, 32'h1000, 32'h03020100, '0);
      repeat (2) step();
      sg_ivalid = 1'b0;
      repeat (3) step();
      check("t5b drain mem_req", mem_req, 0);
      rsp_en = 1'b1;
      repeat (3) step();
      check("t5b nreq", 64'(log_n), 1);
      check("t5b no idone", 64'(idone_cnt), 64'(i0));
      rd_val = 32'h44332211;
      start(1'b0, 2'd0, 32'h1000, 32'h00010203, '0);
      wait_done("t5b", 40);
      check("t5b rd_wdata", cap_wdata, 32'h11223344);
      check("t5b rd_ben", cap_ben, 4'hF);

      // 6: reset while awaiting a response, then a stray response reaches IDLE.
      i0 = idone_cnt;
      rsp_en = 1'b0;
      start(1'b0, 2'd0, 32'h1000, 32'h03020100, '0);
      repeat (2) step();
      g_resetn  = 1'b0;
      sg_ivalid = 1'b0;
      step();
      g_resetn = 1'b1;
      rsp_en   = 1'b1;
      repeat (3) step();
      check_quiet("t6");
      check("t6 no idone", 64'(idone_cnt), 64'(i0));

      // 6b: address wrap, 0xFFFFFFFC + 8.
      rd_val = 32'hCAFEF00D;
      start(1'b0, 2'd2, 32'hFFFFFFFC, 32'h00000008, '0);
      wait_done("t6b", 20);
      check("t6b nreq", 64'(log_n), 1);
      check("t6b addr", log_addr[0], 32'h00000004);
      check("t6b rd_wdata", cap_wdata, 32'hCAFEF00D);
      check("t6b rd_ben", cap_ben, 4'hF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
